trap_csr_unit: RTL and testbench
================================

Name: trap_csr_unit

Overview:
Machine-mode trap controller directly downstream of the exception detector. Consumes excPresent/excCause/trapInfo and commits mepc/mcause/mtval/mstatus at the clock edge, then produces the PC redirect for trap entry and mret. Owns the machine timer (mtime/mtimecmp) and drives mtime_exc back into the exception detector. Also serves CSR reads and writes for the execute stage.

Parameters:
RESET_MTVEC, 32'h0000_0100, mtvec value after reset (MODE=0, direct).
TIMER_PRESCALE, 1, clk cycles per mtime increment; must be >=1.
PRESCALE_W, 8, prescaler counter width; must satisfy TIMER_PRESCALE <= 2**PRESCALE_W.

Ports:
clk_i  in  1  core clock
rst_i  in  1  asynchronous reset, active-high
excPresent_i  in  1  trap request from the exception detector
excCause_i  in  32  synchronous cause code
trapInfo_i  in  32  value for mtval
pc_i  in  32  PC of the current instruction
mret_i  in  1  current instruction is a valid mret
csr_we_i  in  1  CSR write enable
csr_addr_i  in  12  CSR address
csr_wdata_i  in  32  CSR write data (already merged for set/clear)
csr_rdata_o  out  32  combinational read data
csr_valid_o  out  1  csr_addr_i is implemented
trap_redirect_o  out  1  take trap_pc_o this cycle
trap_pc_o  out  32  redirect target
mtime_exc_o  out  1  timer interrupt pending and enabled
mie_o  out  1  mstatus.MIE

Behaviour:
- Reset (async, rst_i=1): mstatus.MIE=0, MPIE=0, mie.MTIE=0, mepc=0, mcause=0, mtval=0, mscratch=0, mtvec=RESET_MTVEC, mtime=0, prescaler=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, mtip=0. Outputs: trap_redirect_o=0, mtime_exc_o=0, mie_o=0.
- Implemented CSRs: mstatus 0x300 (MIE bit3, MPIE bit7, MPP bits12:11 read as 2'b11), mie 0x304 (bit7), mtvec 0x305, mscratch 0x340, mepc 0x341 (bits1:0 read 0), mcause 0x342, mtval 0x343, mip 0x344 (bit7 read-only), time 0xC01, timeh 0xC81 (read-only), mtimecmp 0x7C0, mtimecmph 0x7C1. All other addresses: csr_valid_o=0, rdata=0, writes ignored.
- Timer: prescaler counts 0..TIMER_PRESCALE-1; on wrap, mtime += 1 (64-bit, wraps to 0 from all-ones). mtip is registered as (mtime >= mtimecmp), unsigned, so it updates one cycle after a compare change. mtime_exc_o = MIE & MTIE & mtip (combinational from registers).
- Interrupt recognition: excPresent_i & mtime_exc_o & (trapInfo_i==0). In that case mcause=32'h8000_0007 and mtval=0; otherwise mcause=excCause_i and mtval=trapInfo_i. A misaligned-jump cause always has a nonzero trapInfo, so the two never alias.
- Trap entry (excPresent_i=1): trap_redirect_o=1 in the same cycle. trap_pc_o = {mtvec[31:2],2'b00}; if mtvec MODE=1 and the trap is an interrupt, add 4*7. At the edge: mepc<=pc_i, write mcause/mtval, MPIE<=MIE, MIE<=0.
- mret (mret_i=1, excPresent_i=0): trap_redirect_o=1, trap_pc_o=mepc. At the edge: MIE<=MPIE, MPIE<=1.
- Priority within one cycle, highest first: excPresent_i, then mret_i, then csr_we_i. A CSR write is dropped whenever a trap or mret commits in the same cycle.
- CSR write: takes effect at the edge. A write to mtvec masks bit1 to 0. A write to mtimecmp/mtimecmph replaces that half only; mtip reflects the new value one cycle later.
- No FSM besides the timer: single-cycle commit, no stall, zero added latency on the redirect.

Decomposition:
- Shared package: CSR address constants, mcause interrupt constant (M_TIMER_INT = 32'h8000_0007), mstatus bit-index constants, mtvec mode enum.
- Exception cause codes are reused from the existing package.
- One natural sub-module: mtimer (prescaler, 64-bit mtime, mtimecmp halves, registered mtip).

Test Plan:
1. Reset: assert rst_i without clk -> outputs zero immediately; mtvec reads 0x100; mtimecmp reads 0xFFFF_FFFF.
2. Illegal instruction: excPresent_i=1, excCause_i=2, trapInfo_i=pc_i=0x400 -> trap_pc_o=0x100 same cycle; next cycle mepc=0x400, mcause=2, mtval=0x400, MIE=0.
3. Timer: PRESCALE=1, mtimecmp=10, MTIE=1, MIE=1 -> mtip rises the cycle after mtime=10. Feed back excPresent_i=1, trapInfo_i=0 -> mcause=0x8000_0007; with mtvec=0x101, trap_pc_o=0x11C.
4. mret: MPIE=1, mepc=0x404 -> trap_redirect_o=1, trap_pc_o=0x404; next cycle MIE=1, MPIE=1.
5. Collision: csr_we_i to mscratch with excPresent_i=1 -> mscratch unchanged. mret_i with excPresent_i=1 -> trap entry taken, MIE=0.
6. Wrap: mtime=64'hFFFF_FFFF_FFFF_FFFF, one tick -> time=0, timeh=0; mtip falls.

Source files
------------

// File: rtl/trap_csr_unit_pkg.sv
// ----------------------------------------------------------------------------
// trap_csr_unit_pkg: CSR addresses, trap constants and mtvec mode. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package trap_csr_unit_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_TIME      = 12'hC01;
  localparam logic [11:0] CSR_TIMEH     = 12'hC81;
  localparam logic [11:0] CSR_MTIMECMP  = 12'h7C0;
  localparam logic [11:0] CSR_MTIMECMPH = 12'h7C1;

  localparam logic [31:0] M_TIMER_INT      = 32'h8000_0007;
  localparam logic [31:0] MTVEC_VEC_OFFSET = 32'd28;  // 4 * timer cause number

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MIE_MTIE_BIT     = 7;

  typedef enum logic [1:0] {
    MTVEC_DIRECT   = 2'b00,
    MTVEC_VECTORED = 2'b01
  } mtvec_mode_e;

endpackage

`default_nettype wire

// File: rtl/trap_csr_unit_mtimer.sv
// ----------------------------------------------------------------------------
// trap_csr_unit_mtimer: prescaled 64-bit mtime, mtimecmp and registered mtip. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module trap_csr_unit_mtimer #(
  parameter int TIMER_PRESCALE = 1,
  parameter int PRESCALE_W     = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmp_lo_we,
  input  logic        cmp_hi_we,
  input  logic [31:0] wdata,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        mtip
);

  localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(TIMER_PRESCALE - 1);

  logic [PRESCALE_W-1:0] prescaler;
  logic [63:0]           mtime_q;
  logic [63:0]           mtimecmp_q;
  logic                  mtip_q;
  logic                  tick;

  assign tick     = (prescaler == PRESCALE_LAST);
  assign mtime    = mtime_q;
  assign mtimecmp = mtimecmp_q;
  assign mtip     = mtip_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prescaler  <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      mtip_q     <= 1'b0;
    end else begin
      prescaler <= tick ? '0 : prescaler + PRESCALE_W'(1);
      if (tick) mtime_q <= mtime_q + 64'd1;
      if (cmp_lo_we) mtimecmp_q[31:0]  <= wdata;
      if (cmp_hi_we) mtimecmp_q[63:32] <= wdata;
      // Compare uses the current registers, so mtip lags any change by a cycle.
      mtip_q <= (mtime_q >= mtimecmp_q);
    end
  end

endmodule

`default_nettype wire

// File: rtl/trap_csr_unit.sv
// ----------------------------------------------------------------------------
// trap_csr_unit: M-mode trap commit, mret redirect, CSR file and timer. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module trap_csr_unit
  import trap_csr_unit_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC    = 32'h0000_0100,
  parameter int          TIMER_PRESCALE = 1,
  parameter int          PRESCALE_W     = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        excPresent_i,
  input  logic [31:0] excCause_i,
  input  logic [31:0] trapInfo_i,
  input  logic [31:0] pc_i,
  input  logic        mret_i,
  input  logic        csr_we_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_valid_o,
  output logic        trap_redirect_o,
  output logic [31:0] trap_pc_o,
  output logic        mtime_exc_o,
  output logic        mie_o
);

  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic        mtie;
  logic [31:0] mtvec;
  logic [31:0] mscratch;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] mtval;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        mtip;
  logic        is_int;
  logic        csr_wr;
  logic [31:0] trap_base;

  assign mtime_exc_o = mstatus_mie & mtie & mtip;
  assign mie_o       = mstatus_mie;
  assign is_int      = excPresent_i & mtime_exc_o & (trapInfo_i == 32'd0);
  assign csr_wr      = csr_we_i & ~excPresent_i & ~mret_i;
  assign trap_base   = {mtvec[31:2], 2'b00};

  trap_csr_unit_mtimer #(
    .TIMER_PRESCALE (TIMER_PRESCALE),
    .PRESCALE_W     (PRESCALE_W)
  ) u_mtimer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .cmp_lo_we (csr_wr && (csr_addr_i == CSR_MTIMECMP)),
    .cmp_hi_we (csr_wr && (csr_addr_i == CSR_MTIMECMPH)),
    .wdata     (csr_wdata_i),
    .mtime     (mtime),
    .mtimecmp  (mtimecmp),
    .mtip      (mtip)
  );

  always_comb begin
    trap_redirect_o = 1'b0;
    trap_pc_o       = 32'd0;
    if (excPresent_i) begin
      trap_redirect_o = 1'b1;
      if ((mtvec_mode_e'(mtvec[1:0]) == MTVEC_VECTORED) && is_int)
        trap_pc_o = trap_base + MTVEC_VEC_OFFSET;
      else
        trap_pc_o = trap_base;
    end else if (mret_i) begin
      trap_redirect_o = 1'b1;
      trap_pc_o       = {mepc[31:2], 2'b00};
    end
  end

  always_comb begin
    csr_valid_o = 1'b1;
    csr_rdata_o = 32'd0;
    case (csr_addr_i)
      CSR_MSTATUS:   csr_rdata_o = {19'd0, 2'b11, 3'd0, mstatus_mpie, 3'd0, mstatus_mie, 3'd0};
      CSR_MIE:       csr_rdata_o = {24'd0, mtie, 7'd0};
      CSR_MTVEC:     csr_rdata_o = mtvec;
      CSR_MSCRATCH:  csr_rdata_o = mscratch;
      CSR_MEPC:      csr_rdata_o = {mepc[31:2], 2'b00};
      CSR_MCAUSE:    csr_rdata_o = mcause;
      CSR_MTVAL:     csr_rdata_o = mtval;
      CSR_MIP:       csr_rdata_o = {24'd0, mtip, 7'd0};
      CSR_TIME:      csr_rdata_o = mtime[31:0];
      CSR_TIMEH:     csr_rdata_o = mtime[63:32];
      CSR_MTIMECMP:  csr_rdata_o = mtimecmp[31:0];
      CSR_MTIMECMPH: csr_rdata_o = mtimecmp[63:32];
      default:       csr_valid_o = 1'b0;
    endcase
  end

  // Trap entry outranks mret, which outranks any CSR write in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mtie         <= 1'b0;
      mtvec        <= RESET_MTVEC;
      mscratch     <= 32'd0;
      mepc         <= 32'd0;
      mcause       <= 32'd0;
      mtval        <= 32'd0;
    end else if (excPresent_i) begin
      mepc         <= pc_i;
      mcause       <= is_int ? M_TIMER_INT : excCause_i;
      mtval        <= is_int ? 32'd0 : trapInfo_i;
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (mret_i) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (csr_wr) begin
      case (csr_addr_i)
        CSR_MSTATUS: begin
          mstatus_mie  <= csr_wdata_i[MSTATUS_MIE_BIT];
          mstatus_mpie <= csr_wdata_i[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:      mtie     <= csr_wdata_i[MIE_MTIE_BIT];
        CSR_MTVEC:    mtvec    <= csr_wdata_i & ~32'h0000_0002;
        CSR_MSCRATCH: mscratch <= csr_wdata_i;
        CSR_MEPC:     mepc     <= csr_wdata_i;
        CSR_MCAUSE:   mcause   <= csr_wdata_i;
        CSR_MTVAL:    mtval    <= csr_wdata_i;
        default:      ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_trap_csr_unit.sv
// ----------------------------------------------------------------------------
// tb_trap_csr_unit: directed self-checking bench for trap_csr_unit. Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_trap_csr_unit;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        excPresent_i;
  logic [31:0] excCause_i;
  logic [31:0] trapInfo_i;
  logic [31:0] pc_i;
  logic        mret_i;
  logic        csr_we_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] csr_rdata_o;
  logic        csr_valid_o;
  logic        trap_redirect_o;
  logic [31:0] trap_pc_o;
  logic        mtime_exc_o;
  logic        mie_o;

  int n_cmp    = 0;
  int n_err    = 0;
  int exp_time = 0;

  always #10 clk = ~clk;

  trap_csr_unit dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .excPresent_i    (excPresent_i),
    .excCause_i      (excCause_i),
    .trapInfo_i      (trapInfo_i),
    .pc_i            (pc_i),
    .mret_i          (mret_i),
    .csr_we_i        (csr_we_i),
    .csr_addr_i      (csr_addr_i),
    .csr_wdata_i     (csr_wdata_i),
    .csr_rdata_o     (csr_rdata_o),
    .csr_valid_o     (csr_valid_o),
    .trap_redirect_o (trap_redirect_o),
    .trap_pc_o       (trap_pc_o),
    .mtime_exc_o     (mtime_exc_o),
    .mie_o           (mie_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] e);
    csr_addr_i = a;
    #1;
    chk(tag, csr_rdata_o, e);
  endtask

  // Advance one rising edge (mtime ticks every edge at prescale 1) and park on the falling edge.
  task automatic step();
    @(posedge clk);
    exp_time++;
    @(negedge clk);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_we_i    = 1'b1;
    csr_addr_i  = a;
    csr_wdata_i = d;
    step();
    csr_we_i    = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; excPresent_i = 1'b0; excCause_i = '0; trapInfo_i = '0; pc_i = '0;
    mret_i = 1'b0; csr_we_i = 1'b0; csr_addr_i = '0; csr_wdata_i = '0;
    #1;
    chk("rst_redirect", {31'd0, trap_redirect_o}, 32'd0);
    chk("rst_mtime_exc", {31'd0, mtime_exc_o}, 32'd0);
    chk("rst_mie", {31'd0, mie_o}, 32'd0);
    rd("rst_mtvec", 12'h305, 32'h0000_0100);
    rd("rst_mtimecmp", 12'h7C0, 32'hFFFF_FFFF);
    rd("rst_mtimecmph", 12'h7C1, 32'hFFFF_FFFF);
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    exp_time = 0;
    rd("time_after_rst", 12'hC01, 32'd0);
    rd("mstatus_rst", 12'h300, 32'h0000_1800);
    rd("invalid_rdata", 12'h123, 32'd0);
    chk("invalid_valid", {31'd0, csr_valid_o}, 32'd0);

    // Illegal instruction trap
    excPresent_i = 1'b1; excCause_i = 32'd2; trapInfo_i = 32'h400; pc_i = 32'h400;
    #1;
    chk("ill_redirect", {31'd0, trap_redirect_o}, 32'd1);
    chk("ill_trap_pc", trap_pc_o, 32'h100);
    step();
    excPresent_i = 1'b0;
    rd("ill_mepc", 12'h341, 32'h400);
    rd("ill_mcause", 12'h342, 32'd2);
    rd("ill_mtval", 12'h343, 32'h400);
    chk("ill_mie", {31'd0, mie_o}, 32'd0);

    // Timer setup: MIE, MTIE, vectored mtvec (bit1 masked), mtimecmp = 10
    wr(12'h300, 32'h0000_0008);
    wr(12'h304, 32'h0000_0080);
    wr(12'h305, 32'h0000_0103);
    rd("mtvec_masked", 12'h305, 32'h0000_0101);
    wr(12'h7C0, 32'd10);
    wr(12'h7C1, 32'd0);
    rd("mtimecmp_lo", 12'h7C0, 32'd10);
    while (exp_time < 10) step();
    rd("time_10", 12'hC01, 32'd10);
    rd("mip_before", 12'h344, 32'd0);
    chk("mtime_exc_before", {31'd0, mtime_exc_o}, 32'd0);
    step();
    chk("mtime_exc_rise", {31'd0, mtime_exc_o}, 32'd1);
    rd("mip_after", 12'h344, 32'h80);

    // Interrupt trap with a colliding mscratch write
    excPresent_i = 1'b1; excCause_i = 32'd5; trapInfo_i = 32'd0; pc_i = 32'h500;
    csr_we_i = 1'b1; csr_addr_i = 12'h340; csr_wdata_i = 32'hDEAD;
    #1;
    chk("int_redirect", {31'd0, trap_redirect_o}, 32'd1);
    chk("int_trap_pc", trap_pc_o, 32'h11C);
    step();
    excPresent_i = 1'b0; csr_we_i = 1'b0;
    rd("int_mcause", 12'h342, 32'h8000_0007);
    rd("int_mtval", 12'h343, 32'd0);
    rd("int_mepc", 12'h341, 32'h500);
    rd("int_mscratch", 12'h340, 32'd0);
    rd("int_mstatus", 12'h300, 32'h0000_1880);
    chk("int_mtime_exc", {31'd0, mtime_exc_o}, 32'd0);

    // mret to 0x404 (low bits of mepc read as zero)
    wr(12'h341, 32'h406);
    rd("mepc_masked", 12'h341, 32'h404);
    mret_i = 1'b1;
    #1;
    chk("mret_redirect", {31'd0, trap_redirect_o}, 32'd1);
    chk("mret_pc", trap_pc_o, 32'h404);
    step();
    mret_i = 1'b0;
    chk("mret_mie", {31'd0, mie_o}, 32'd1);
    rd("mret_mstatus", 12'h300, 32'h0000_1888);
    chk("mret_mtime_exc", {31'd0, mtime_exc_o}, 32'd1);

    // Trap and mret together: trap wins, non-interrupt goes to base even in vectored mode
    excPresent_i = 1'b1; mret_i = 1'b1; excCause_i = 32'd11; trapInfo_i = 32'h77; pc_i = 32'h600;
    #1;
    chk("coll_trap_pc", trap_pc_o, 32'h100);
    step();
    excPresent_i = 1'b0;
    chk("coll_mie", {31'd0, mie_o}, 32'd0);
    rd("coll_mcause", 12'h342, 32'd11);
    rd("coll_mtval", 12'h343, 32'h77);
    rd("coll_mepc", 12'h341, 32'h600);

    // mret with a colliding CSR write: write dropped
    csr_we_i = 1'b1; csr_addr_i = 12'h340; csr_wdata_i = 32'h55;
    step();
    mret_i = 1'b0; csr_we_i = 1'b0;
    rd("mret_coll_mscratch", 12'h340, 32'd0);
    chk("mret_coll_mie", {31'd0, mie_o}, 32'd1);

    // mtime wrap from all-ones
    force dut.u_mtimer.mtime_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.u_mtimer.mtime_q;
    rd("wrap_pre_timeh", 12'hC81, 32'hFFFF_FFFF);
    step();
    rd("wrap_time", 12'hC01, 32'd0);
    rd("wrap_timeh", 12'hC81, 32'd0);
    rd("wrap_mip_hold", 12'h344, 32'h80);
    step();
    rd("wrap_mip_fall", 12'h344, 32'd0);
    chk("wrap_mtime_exc", {31'd0, mtime_exc_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
